rr_mux_nx1: RTL
===============

# rr_mux_nx1

Parametrised N-to-1 streaming multiplexer: the registered, handshaked successor to the combinational 8:1 mux. N input channels of W bits each compete for one output, and a round-robin arbiter replaces the external select lines. The winning word is captured in a single output register with valid/ready flow control. It sits between multiple producer blocks and a single shared consumer, such as a bus or serializer.

## Interface
- N, 8: number of input channels (2..32).
- W, 8: data width per channel (1..64).
- SW (localparam), $clog2(N): width of the grant index.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel word-available flag.
- in_last  in  N  per-channel end-of-packet flag; used only when the lock feature is enabled.
- in_ready  out  N  per-channel accept; at most one bit high per cycle.
- out_data  out  W  registered selected word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accept.
- out_sel  out  SW  index of the channel that supplied out_data.
- out_last  out  1  registered in_last of the selected word.

## Operation
- Output register state:
  - `load = !out_valid || out_ready`.
  - The register loads on every cycle where `load` is high.
  - Channel i's word transfers when `in_valid[i] && in_ready[i]`.
  - The output word transfers when `out_valid && out_ready`.
- Arbitration (combinational, on each cycle `load` is high):
  - The grant g is the first i with `in_valid[i]=1`, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - `in_ready[g]=1`; all other in_ready bits are 0.
  - If `load=0`, in_ready is all zeros.
- On load:
  - With a grant: out_data, out_sel and out_last take channel g's values, out_valid is set to 1, and ptr is set to (g+1) mod N.
  - With no valid input: out_valid is set to 0, and out_data, out_sel and out_last hold their values.
- ptr wraps from N-1 to 0. A channel that is continuously valid is served at least once every N accepted words.
- in_ready must not depend combinationally on in_data. It may depend on in_valid and out_ready.
- Reset: out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, lock cleared. Reset asserted mid-transfer discards the held word with no partial state. In-flight producer words are not accepted during reset.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on out_data/out_valid after edge k.
- Throughput is 1 word/cycle while out_ready stays high, with zero bubbles across channel switches.
- Backpressure:
  - If out_ready=0 while out_valid=1, in_ready is all zeros and the outputs hold stable.
  - A producer must hold in_data/in_valid stable until it is accepted.
- Simultaneous pop and push in one cycle is legal: the old word leaves and the new word loads on the same edge.

## Configuration
- RR_MUX_LAST_LOCK_EN defined:
  - Accepting a word with in_last=0 from channel g sets lock and locks the arbiter to g.
  - While locked, only g is eligible and ptr does not advance.
  - Accepting g's word with in_last=1 clears lock and sets ptr=(g+1) mod N.
  - An idle locked channel (in_valid[g]=0) stalls the output.
- Macro undefined:
  - The lock logic is absent.
  - Every word is arbitrated independently.
  - in_last is passed through to out_last only.

## Test plan
- Reset: assert rst for 3 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
- Fairness: N=8, all in_valid=1, channel i data=0x10+i, out_ready=1. Required: out_sel sequence 0,1,...,7,0,1 with one word per cycle and out_data matching.
- Sparse/wrap: only channels 6 and 1 valid, ptr=7. Required: channel 1 is granted first, then 6, then 1.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 and data 0x33. Required: out_data stays 0x33, in_ready=0. After out_ready=1, the next word appears 1 cycle later.
- Lock (macro defined): channel 2 sends 3 words with last=0,0,1 while channel 3 is valid. Required: out_sel=2,2,2, then 3.
- Lock (macro undefined): same stimulus. Required: out_sel alternates 2,3,2,3,2.

Source files
------------

// File: rtl/rr_mux_nx1.sv
// N-to-1 round-robin streaming mux with a single registered valid/ready output stage.
// Define RR_MUX_LAST_LOCK_EN to hold the grant on one channel until it sends in_last=1.
module rr_mux_nx1 #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*W-1:0]        in_data,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0]          in_last,
  output logic [N-1:0]          in_ready,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(N)-1:0]  out_sel,
  output logic                  out_last
);

  localparam int SW = $clog2(N);

  logic [W-1:0]  r_data;
  logic          r_valid;
  logic [SW-1:0] r_sel;
  logic          r_last;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic [N-1:0]  w_elig;
  logic          w_found;
  logic [SW-1:0] w_grant;
  logic [SW-1:0] w_ptr_inc;
  logic [N-1:0]  w_onehot;

  assign w_load = !r_valid || out_ready;

`ifdef RR_MUX_LAST_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lock_ch;

  always_comb begin
    w_elig = in_valid;
    if (r_lock) begin
      w_elig = in_valid & ({{(N-1){1'b0}}, 1'b1} << r_lock_ch);
    end
  end
`else
  always_comb begin
    w_elig = in_valid;
  end
`endif

  // Rotating priority search; the sum is one bit wider so the wrap test never overflows.
  always_comb begin : arb
    logic [SW:0]   v_sum;
    logic [SW-1:0] v_idx;
    w_found = 1'b0;
    w_grant = '0;
    v_sum   = '0;
    v_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_sum = {1'b0, r_ptr} + (SW+1)'(k);
      if (v_sum >= (SW+1)'(N)) begin
        v_sum = v_sum - (SW+1)'(N);
      end
      v_idx = v_sum[SW-1:0];
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_grant = v_idx;
      end
    end
  end

  assign w_ptr_inc = (w_grant == SW'(N-1)) ? '0 : w_grant + 1'b1;
  assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_grant;
  assign in_ready  = (w_load && w_found && !rst) ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_last  <= 1'b0;
      r_ptr   <= '0;
`ifdef RR_MUX_LAST_LOCK_EN
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
`endif
    end else if (w_load) begin
      if (w_found) begin
        r_data  <= in_data[w_grant*W +: W];
        r_valid <= 1'b1;
        r_sel   <= w_grant;
        r_last  <= in_last[w_grant];
`ifdef RR_MUX_LAST_LOCK_EN
        if (in_last[w_grant]) begin
          r_lock <= 1'b0;
          r_ptr  <= w_ptr_inc;
        end else begin
          r_lock    <= 1'b1;
          r_lock_ch <= w_grant;
        end
`else
        r_ptr <= w_ptr_inc;
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  assign out_last  = r_last;

endmodule
